// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_port_arbiter
//  Purpose  : Shares one Wishbone port-type slave (bidirectional, input-only
//             or output-only port) between NUM_MASTERS bus masters. Grants
//             are round-robin and held for a whole bus cycle (cyc). Ack and
//             read data go back to the granted master only. A per-transfer
//             watchdog answers with err when the slave never acks.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      : system clock, logic on posedge
//    rst      : asynchronous, active-low reset
//    mWbCycI  : per-master cyc
//    mWbStbI  : per-master stb
//    mWbWeI   : per-master we
//    mWbAdrI  : per-master address, master i at slice i
//    mWbDatI  : per-master write data, master i at slice i
//    mWbAckO  : per-master ack
//    mWbErrO  : per-master err, one-clock watchdog pulse
//    mWbDatO  : slave read data, broadcast to all masters
//    sWbCycO  : slave cyc
//    sWbStbO  : slave stb
//    sWbWeO   : slave we
//    sWbAdrO  : slave address
//    sWbDatO  : slave write data
//    sWbAckI  : slave ack
//    sWbDatI  : slave read data
//    grantO   : one-hot current grant, all zero while idle
// ============================================================================
module wb_port_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 1,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            mWbCycI,
    input  logic [NUM_MASTERS-1:0]            mWbStbI,
    input  logic [NUM_MASTERS-1:0]            mWbWeI,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] mWbAdrI,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] mWbDatI,
    output logic [NUM_MASTERS-1:0]            mWbAckO,
    output logic [NUM_MASTERS-1:0]            mWbErrO,
    output logic [DATA_WIDTH-1:0]             mWbDatO,
    output logic                              sWbCycO,
    output logic                              sWbStbO,
    output logic                              sWbWeO,
    output logic [ADDR_WIDTH-1:0]             sWbAdrO,
    output logic [DATA_WIDTH-1:0]             sWbDatO,
    input  logic                              sWbAckI,
    input  logic [DATA_WIDTH-1:0]             sWbDatI,
    output logic [NUM_MASTERS-1:0]            grantO
);

    localparam int c_IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    // Last-grant pointer starts at the top master so master 0 wins first.
    localparam logic [c_IDX_W-1:0] c_LAST_RESET = c_IDX_W'(NUM_MASTERS - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_M1 = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_stateNext;
    logic [c_IDX_W-1:0]     r_grantIdx;
    logic [c_IDX_W-1:0]     r_lastIdx;
    logic [c_IDX_W-1:0]     w_pickIdx;
    logic                   w_pickValid;
    logic [c_CNT_W-1:0]     r_wdogCnt;
    logic                   r_lockout;
    logic                   r_errPulse;
    logic                   w_granted;
    logic                   w_gCyc;
    logic                   w_gStb;
    logic                   w_stall;
    logic                   w_timeoutHit;
    logic [NUM_MASTERS-1:0] w_grantVec;

    // ------------------------------------------------------------------
    // Round-robin pick: first requester above the last grant, wrapping.
    // ------------------------------------------------------------------
    always_comb begin
        w_pickValid = 1'b0;
        w_pickIdx   = r_lastIdx;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            if (!w_pickValid &&
                mWbCycI[c_IDX_W'((int'(r_lastIdx) + k) % NUM_MASTERS)]) begin
                w_pickValid = 1'b1;
                w_pickIdx   = c_IDX_W'((int'(r_lastIdx) + k) % NUM_MASTERS);
            end
        end
    end

    // ------------------------------------------------------------------
    // Request mux from the granted master
    // ------------------------------------------------------------------
    assign w_granted = (r_state == ST_GRANT);
    assign w_gCyc    = mWbCycI[r_grantIdx];
    assign w_gStb    = mWbStbI[r_grantIdx] & ~r_lockout;

    assign sWbCycO = w_granted & w_gCyc;
    assign sWbStbO = w_granted & w_gStb;
    assign sWbWeO  = w_granted & mWbWeI[r_grantIdx];
    assign sWbAdrO = w_granted ? mWbAdrI[int'(r_grantIdx)*ADDR_WIDTH +: ADDR_WIDTH]
                               : '0;
    assign sWbDatO = w_granted ? mWbDatI[int'(r_grantIdx)*DATA_WIDTH +: DATA_WIDTH]
                               : '0;

    assign mWbDatO = sWbDatI;

    // A stalled cycle is a strobe the slave has not answered yet. The hit
    // fires on the stall that brings the count to TIMEOUT_CYCLES, so an ack
    // arriving in that same cycle clears the count first and wins.
    assign w_stall      = sWbStbO & ~sWbAckI;
    assign w_timeoutHit = w_stall & (r_wdogCnt == c_TIMEOUT_M1);

    // ------------------------------------------------------------------
    // Per-master response routing
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_master
        assign w_grantVec[i] = w_granted & (int'(r_grantIdx) == i);
        // sWbStbO is already low while idle or locked out, so stray acks drop.
        assign mWbAckO[i]    = w_grantVec[i] & sWbAckI & sWbStbO;
        assign mWbErrO[i]    = w_grantVec[i] & r_errPulse;
    end

    assign grantO = w_grantVec;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Re-arbitration only happens from IDLE, giving one idle cycle between
    // consecutive grants.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pickValid) begin
                    w_stateNext = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!w_gCyc) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Grant pointers, watchdog and lockout
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grantIdx <= '0;
            r_lastIdx  <= c_LAST_RESET;
            r_wdogCnt  <= '0;
            r_lockout  <= 1'b0;
            r_errPulse <= 1'b0;
        end else begin
            r_errPulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_wdogCnt <= '0;
                    r_lockout <= 1'b0;
                    if (w_pickValid) begin
                        r_grantIdx <= w_pickIdx;
                        r_lastIdx  <= w_pickIdx;
                    end
                end
                ST_GRANT: begin
                    if (!w_gCyc) begin
                        r_wdogCnt <= '0;
                        r_lockout <= 1'b0;
                    end else if (w_timeoutHit) begin
                        // Lockout holds stb low until the master ends the
                        // cycle, so the counter can restart from zero.
                        r_wdogCnt  <= '0;
                        r_lockout  <= 1'b1;
                        r_errPulse <= 1'b1;
                    end else if (w_stall) begin
                        r_wdogCnt <= r_wdogCnt + c_CNT_ONE;
                    end else begin
                        r_wdogCnt <= '0;
                    end
                end
                default: begin
                    r_wdogCnt <= '0;
                    r_lockout <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
